// File: rtl/inst_buffer_pkg.sv
// Shared CPU definitions used by the instruction buffer: entry layout and exception codes.
package cpu_defs;

  localparam int IB_ENTRY_W = 71;
  localparam int ECODE_W    = 6;

  typedef enum logic [ECODE_W-1:0] {
    ECODE_INT  = 6'h00,
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0b,
    ECODE_BRK  = 6'h0c,
    ECODE_INE  = 6'h0d
  } ecode_t;

  // pc[70:39], inst[38:7], excp[6], ecode[5:0]
  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic               excp;
    logic [ECODE_W-1:0] ecode;
  } ib_entry_t;

endpackage

// File: rtl/ib_fifo_ram.sv
// Instruction-buffer storage: one synchronous write port, one combinational read port.
module ib_fifo_ram
  import cpu_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  ib_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output ib_entry_t        rd_data
);

  ib_entry_t mem [DEPTH];

  // Contents are intentionally not reset; only the pointers in the parent are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_buffer.sv
// In-order instruction queue between fetch-check and decode, cleared on any flush.
module inst_buffer
  import cpu_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               excp_flush,
  input  logic               ertn_flush,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_inst,
  input  logic               in_excp,
  input  logic [ECODE_W-1:0] in_ecode,
  output logic               in_ready,
  output logic               in_fire,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_inst,
  output logic               out_excp,
  output logic [ECODE_W-1:0] out_ecode,
  input  logic               out_ready,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             flush_any;
  logic             push;
  logic             pop;
  ib_entry_t        wr_entry;
  ib_entry_t        head;

  assign flush_any = flush | excp_flush | ertn_flush;
  assign in_ready  = (count != FULL_CNT);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (count != '0);

  // A flush drops both the incoming packet and the head consumption of that cycle.
  assign push = in_fire & ~flush_any;
  assign pop  = out_valid & out_ready & ~flush_any;

  assign wr_entry = '{pc: in_pc, inst: in_inst, excp: in_excp, ecode: in_ecode};

  ib_fifo_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_excp  = out_valid & head.excp;
  assign out_ecode = head.ecode;

  always_ff @(posedge clk) begin
    if (reset || flush_any) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: vector table, hand-written corner sequences, random vs queue model.
module tb_inst_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        excp_flush;
  logic        ertn_flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_excp;
  logic [5:0]  in_ecode;
  logic        in_ready;
  logic        in_fire;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;
  logic [5:0]  out_ecode;
  logic        out_ready;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_buffer #(.DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .excp_flush (excp_flush),
    .ertn_flush (ertn_flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_excp    (in_excp),
    .in_ecode   (in_ecode),
    .in_ready   (in_ready),
    .in_fire    (in_fire),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_excp   (out_excp),
    .out_ecode  (out_ecode),
    .out_ready  (out_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exp_fire;
    logic [3:0]  exp_count;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [5:0]  ecode;
  } pkt_t;

  vec_t vecs[10];
  pkt_t model_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change and state is sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; excp_flush = 0; ertn_flush = 0;
    in_valid = 0; in_pc = '0; in_inst = '0; in_excp = 0; in_ecode = '0;
    out_ready = 0;
  endtask

  task automatic clear_queue();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic excp, input logic [5:0] ecode);
    in_valid = 1; in_pc = pc; in_inst = pc ^ 32'h5a5a_0000; in_excp = excp; in_ecode = ecode;
    out_ready = 0;
    tick();
    in_valid = 0; in_excp = 0;
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] next_pc;
    logic [31:0] head_pc;
    int          cyc_or;
    logic        any_flush;
    logic        exp_ready;

    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;

    check("reset_count",     count,     0);
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_excp",  out_excp,  0);

    // Fill to full with out_ready low, then one refused push, then one pop.
    base = 32'h1c00_0000;
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{iv: 1, ordy: 0, pc: base + 32'(4*i),
                  inst: (i == 0) ? 32'h0280_0c21 : (32'h0010_0000 | 32'(i)),
                  exp_fire: 1, exp_count: 4'(i+1), exp_in_ready: (i != 7),
                  exp_out_valid: 1, exp_pc: base};
    end
    vecs[8] = '{iv: 1, ordy: 0, pc: base + 32'd32, inst: 32'h0010_0008, exp_fire: 0,
                exp_count: 4'd8, exp_in_ready: 0, exp_out_valid: 1, exp_pc: base};
    vecs[9] = '{iv: 0, ordy: 1, pc: '0, inst: '0, exp_fire: 0,
                exp_count: 4'd7, exp_in_ready: 1, exp_out_valid: 1, exp_pc: base + 32'd4};

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      in_pc = vecs[i].pc; in_inst = vecs[i].inst;
      @(negedge clk);
      check($sformatf("vec%0d_in_fire", i), in_fire, vecs[i].exp_fire);
      tick();
      check($sformatf("vec%0d_count", i),     count,     vecs[i].exp_count);
      check($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].exp_in_ready);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_out_valid);
      check($sformatf("vec%0d_out_pc", i),    out_pc,    vecs[i].exp_pc);
      if (i == 0) check("vec0_out_inst", out_inst, 32'h0280_0c21);
    end

    // Queue holds 7 entries after the single pop; simultaneous push/pop holds occupancy across the wrap.
    next_pc = base + 32'd32;
    head_pc = base + 32'd4;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1; in_pc = next_pc; in_inst = 32'h0; out_ready = 1;
      @(negedge clk);
      check($sformatf("stream%0d_in_fire", k), in_fire, 1);
      check($sformatf("stream%0d_out_pc", k),  out_pc,  head_pc);
      tick();
      check($sformatf("stream%0d_count", k), count, 7);
      next_pc = next_pc + 32'd4;
      head_pc = head_pc + 32'd4;
    end
    idle_inputs();

    // Flush with a simultaneous incoming packet: queue empties and that packet is lost.
    clear_queue();
    for (int i = 0; i < 5; i++) push_one(32'h2000_0000 + 32'(4*i), 0, '0);
    check("pre_flush_count", count, 5);
    excp_flush = 1; in_valid = 1; in_pc = 32'hdead_0000; out_ready = 1;
    tick();
    idle_inputs();
    check("flush_count",     count,     0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_excp",  out_excp,  0);
    push_one(32'h3000_0000, 0, '0);
    check("post_flush_count", count,  1);
    check("post_flush_pc",    out_pc, 32'h3000_0000);

    // Fetch exception propagation and forced-low excp on an empty queue.
    clear_queue();
    check("empty_out_excp", out_excp, 0);
    push_one(32'h1c00_1000, 1, 6'h08);
    check("excp_out_valid", out_valid, 1);
    check("excp_out_excp",  out_excp,  1);
    check("excp_out_ecode", out_ecode, 6'h08);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("excp_drained_valid", out_valid, 0);
    check("excp_drained_excp",  out_excp,  0);

    // Reset together with flush behaves as reset.
    push_one(32'h1c00_2000, 0, '0);
    reset = 1; ertn_flush = 1; in_valid = 1;
    tick();
    reset = 0; ertn_flush = 0; in_valid = 0;
    check("reset_flush_count",    count,    0);
    check("reset_flush_in_ready", in_ready, 1);

    // Randomized traffic against a queue model, with out_ready bias varying by phase.
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case ((cyc / 500) % 4)
        0:       cyc_or = 20;
        1:       cyc_or = 50;
        2:       cyc_or = 85;
        default: cyc_or = 50;
      endcase
      in_valid   = ($urandom_range(0, 99) < 70);
      out_ready  = ($urandom_range(0, 99) < cyc_or);
      flush      = ($urandom_range(0, 199) == 0);
      excp_flush = ($urandom_range(0, 199) == 0);
      ertn_flush = ($urandom_range(0, 199) == 0);
      in_pc      = $urandom;
      in_inst    = $urandom;
      in_excp    = 1'($urandom_range(0, 1));
      in_ecode   = 6'($urandom_range(0, 63));
      @(negedge clk);
      exp_ready = (model_q.size() < 8);
      check("rnd_count",     count,     64'(model_q.size()));
      check("rnd_in_ready",  in_ready,  exp_ready);
      check("rnd_in_fire",   in_fire,   in_valid & exp_ready);
      check("rnd_out_valid", out_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
        check("rnd_out_pc",    out_pc,    model_q[0].pc);
        check("rnd_out_inst",  out_inst,  model_q[0].inst);
        check("rnd_out_excp",  out_excp,  model_q[0].excp);
        if (model_q[0].excp) check("rnd_out_ecode", out_ecode, model_q[0].ecode);
      end else begin
        check("rnd_empty_excp", out_excp, 0);
      end
      any_flush = flush | excp_flush | ertn_flush;
      if (any_flush) begin
        model_q.delete();
      end else begin
        if (out_ready && model_q.size() != 0) void'(model_q.pop_front());
        if (in_valid && exp_ready) model_q.push_back('{pc: in_pc, inst: in_inst, excp: in_excp, ecode: in_ecode});
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
